// File: rtl/iir_seq_pkg.sv
// Shared types and constants for the IIR filter sequencer.
package iir_seq_pkg;
  localparam int CW    = 16;  // coefficient width
  localparam int SW    = 8;   // sample width
  localparam int NCOEF = 5;

  localparam logic [2:0] ADDR_A1 = 3'd0;
  localparam logic [2:0] ADDR_A2 = 3'd1;
  localparam logic [2:0] ADDR_B0 = 3'd2;
  localparam logic [2:0] ADDR_B1 = 3'd3;
  localparam logic [2:0] ADDR_B2 = 3'd4;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, PROC} state_e;

  typedef struct packed {
    logic          we;
    logic [2:0]    addr;
    logic [CW-1:0] data;
  } cfg_wr_t;
endpackage

// File: rtl/iir_coef_bank.sv
// Five-entry coefficient register file; the read port sees a same-cycle
// write to the addressed entry so a load can start on the write cycle.
module iir_coef_bank
  import iir_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  cfg_wr_t       wr_i,
  input  logic [2:0]    raddr_i,
  output logic [CW-1:0] rdata_o
);
  logic [CW-1:0] bank_q [NCOEF];

  // Coefficient storage; addresses beyond the bank match no entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCOEF; i++) bank_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCOEF; i++)
        if (wr_i.we && wr_i.addr == 3'(i)) bank_q[i] <= wr_i.data;
    end
  end

  // Read mux with write-first bypass.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NCOEF; i++)
      if (raddr_i == 3'(i)) rdata_o = bank_q[i];
    if (wr_i.we && wr_i.addr == raddr_i && raddr_i < 3'(NCOEF)) rdata_o = wr_i.data;
  end
endmodule

// File: rtl/iir_seq_ctrl.sv
// Sequencer for one IIR filter: replays the coefficient bank into the
// filter's params load, feeds one sample at a time, captures the result at
// a fixed latency and reports done/timeout status.
module iir_seq_ctrl
  import iir_seq_pkg::*;
#(
  parameter int DOUT_LAT = 10,
  parameter int TIMEOUT  = 64,
  parameter int TW       = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  input  logic          cmd_load,
  input  logic          s_valid,
  input  logic [SW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [SW-1:0] m_data,
  output logic          iir_start,
  output logic [CW-1:0] params,
  output logic          start,
  output logic [SW-1:0] din,
  input  logic          ready,
  input  logic [SW-1:0] dout,
  input  logic          iir_done,
  output logic          busy,
  output logic          done_sticky,
  output logic          err_timeout
);
  localparam int LW = $clog2(DOUT_LAT + 1);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          done_q, done_d, err_q, err_d, mv_q, mv_d;
  logic [SW-1:0] md_q, md_d;
  logic [2:0]    raddr;
  logic [CW-1:0] rdata;
  cfg_wr_t       wr;

  // Host writes only land while the sequencer is idle.
  assign wr.we   = cfg_we && (state_q == IDLE);
  assign wr.addr = cfg_addr;
  assign wr.data = cfg_wdata;

  iir_coef_bank u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (wr),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mv_q    <= 1'b0;
      md_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
    end
  end

  // Next-state and filter-side handshake; timeout counter clears outside WAIT.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = '0;
    lat_d     = lat_q;
    done_d    = done_q;
    err_d     = err_q;
    mv_d      = 1'b0;
    md_d      = md_q;
    raddr     = ADDR_A1;
    iir_start = 1'b0;
    start     = 1'b0;
    din       = '0;
    s_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_load) begin
          iir_start = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          idx_d     = ADDR_A2;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        raddr = idx_q;
        if (idx_q == ADDR_B2) state_d = WAIT;
        else                  idx_d   = idx_q + 3'd1;
      end
      WAIT: begin
        s_ready = ready;
        if (ready) begin
          if (s_valid) begin
            start   = 1'b1;
            din     = s_data;
            lat_d   = LW'(1);
            state_d = PROC;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      PROC: begin
        // ready is stale right after start, so only the latency count matters.
        if (lat_q == LW'(DOUT_LAT)) begin
          md_d    = dout;
          mv_d    = 1'b1;
          state_d = WAIT;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A done pulse wins over a same-cycle clear.
    if (iir_done) done_d = 1'b1;
  end

  assign params      = rdata;
  assign m_valid     = mv_q;
  assign m_data      = md_q;
  assign busy        = (state_q != IDLE);
  assign done_sticky = done_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_iir_seq_ctrl.sv
// Bench for iir_seq_ctrl: a behavioural filter model drives ready/dout, and
// a scoreboard checks handshakes, load sequences and result timing.
module tb_iir_seq_ctrl;
  import iir_seq_pkg::*;
  localparam int DOUT_LAT = 10;
  localparam int TIMEOUT  = 64;

  logic        clk, reset, cfg_we, cmd_load, s_valid, s_ready, m_valid;
  logic        iir_start, start, ready, iir_done, busy, done_sticky, err_timeout;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata, params;
  logic [7:0]  s_data, m_data, din, dout;

  iir_seq_ctrl #(.DOUT_LAT(DOUT_LAT), .TIMEOUT(TIMEOUT), .TW(7)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cmd_load(cmd_load), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data),
    .iir_start(iir_start), .params(params), .start(start), .din(din),
    .ready(ready), .dout(dout), .iir_done(iir_done), .busy(busy),
    .done_sticky(done_sticky), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc_n = 0;
  // filter model
  bit   tie_low = 0;
  int   rdy_from = -1, dout_at = -1, extra_max = 0;
  logic [7:0] dout_val = 8'h00;
  // scoreboard
  typedef struct { int t; logic [7:0] v; } res_t;
  res_t        resq[$];
  logic [15:0] pexp[$];
  logic [15:0] bank_m[5];
  int          st_q[$];
  int          n_start = 0, n_mv = 0, t_ist = -1;

  typedef struct {
    logic we; logic [2:0] addr; logic [15:0] wd; logic ld;
    logic e_ist; logic e_busy; logic pchk; logic [15:0] e_par;
  } vec_t;
  vec_t tv[12];

  function automatic logic [7:0] fexp(logic [7:0] d);
    return (d ^ 8'hA5) + 8'd7;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_params"}, 32'(params), 0);
    chk({tag, "_ctl"}, 32'({iir_start, start, s_ready, m_valid, busy, done_sticky, err_timeout}), 0);
    chk({tag, "_data"}, 32'({din, m_data}), 0);
  endtask

  task automatic model_clear();
    resq.delete(); pexp.delete();
    rdy_from = -1; dout_at = -1;
    for (int i = 0; i < 5; i++) bank_m[i] = '0;
  endtask

  // Observe the current cycle at the falling edge and update the models.
  task automatic settle();
    bit exp_mv;
    @(negedge clk);
    if (!reset) begin
      chk("start_rule", 32'(start), 32'(s_valid & s_ready));
      chk("start_needs_ready", 32'(start & ~ready), 0);
      if (start) chk("din", 32'(din), 32'(s_data));
      if (busy && ready && s_valid && resq.size() == 0) chk("start_when_free", 32'(start), 1);
      chk("iir_start_rule", 32'(iir_start), 32'(cmd_load & ~busy));
      if (cfg_we && !busy && cfg_addr < 3'd5) bank_m[cfg_addr] = cfg_wdata;
      if (iir_start) begin
        pexp.delete();
        for (int i = 0; i < 5; i++) pexp.push_back(bank_m[i]);
        t_ist = cyc_n;
        rdy_from = cyc_n + 6;
      end
      if (pexp.size() > 0) chk("params_seq", 32'(params), 32'(pexp.pop_front()));
      exp_mv = (resq.size() > 0 && resq[0].t == cyc_n);
      chk("m_valid_timing", 32'(m_valid), 32'(exp_mv));
      if (exp_mv) begin
        if (m_valid) begin
          chk("m_data", 32'(m_data), 32'(resq[0].v));
          n_mv++;
        end
        void'(resq.pop_front());
      end
      if (start) begin
        resq.push_back('{cyc_n + DOUT_LAT + 1, fexp(din)});
        st_q.push_back(cyc_n);
        n_start++;
        rdy_from = cyc_n + DOUT_LAT + 2 + int'($urandom_range(0, extra_max));
        dout_at  = cyc_n + DOUT_LAT;
        dout_val = fexp(din);
      end
    end
  endtask

  // Step to the next cycle and drive the filter-side inputs.
  task automatic adv();
    logic [7:0] g;
    bit nr;
    nr = !tie_low && rdy_from >= 0 && (cyc_n + 1) >= rdy_from;
    @(posedge clk); #1;
    cyc_n++;
    ready = nr;
    g = 8'($urandom);
    if (g == dout_val) g = ~g;
    dout = (cyc_n == dout_at) ? dout_val : g;
  endtask

  task automatic cyc();
    settle(); adv();
  endtask

  // Offer one sample and wait (bounded) for its start pulse.
  task automatic send(input logic [7:0] d, output int t);
    bit got;
    got = 0; t = -1;
    s_valid = 1'b1; s_data = d;
    for (int k = 0; k < 30 && !got; k++) begin
      settle();
      if (start) begin got = 1; t = cyc_n; end
      adv();
    end
    s_valid = 1'b0;
    chk("send_started", 32'(got), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t_idle, sent, ns0, nm0;
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cmd_load = 0; s_valid = 0;
    s_data = 0; ready = 0; dout = 0; iir_done = 0; reset = 0;
    model_clear();
    #1 reset = 1;
    #2 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Coefficient writes and load replay, including dropped writes.
    tv[0]  = '{1, 3'd0, 16'h0100, 0, 0, 0, 1, 16'h0100};
    tv[1]  = '{1, 3'd1, 16'hFF80, 0, 0, 0, 1, 16'h0100};
    tv[2]  = '{1, 3'd2, 16'h0040, 0, 0, 0, 1, 16'h0100};
    tv[3]  = '{1, 3'd3, 16'h0020, 0, 0, 0, 1, 16'h0100};
    tv[4]  = '{1, 3'd4, 16'h0010, 0, 0, 0, 1, 16'h0100};
    tv[5]  = '{1, 3'd5, 16'hDEAD, 0, 0, 0, 1, 16'h0100};
    tv[6]  = '{0, 3'd0, 16'h0000, 1, 1, 0, 1, 16'h0100};
    tv[7]  = '{0, 3'd0, 16'h0000, 0, 0, 1, 1, 16'hFF80};
    tv[8]  = '{1, 3'd2, 16'h1234, 0, 0, 1, 1, 16'h0040};
    tv[9]  = '{0, 3'd0, 16'h0000, 1, 0, 1, 1, 16'h0020};
    tv[10] = '{0, 3'd0, 16'h0000, 0, 0, 1, 1, 16'h0010};
    tv[11] = '{0, 3'd0, 16'h0000, 0, 0, 1, 0, 16'h0000};
    for (int i = 0; i < 12; i++) begin
      cfg_we = tv[i].we; cfg_addr = tv[i].addr; cfg_wdata = tv[i].wd; cmd_load = tv[i].ld;
      settle();
      chk($sformatf("tv%0d_iir_start", i), 32'(iir_start), 32'(tv[i].e_ist));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      if (tv[i].pchk) chk($sformatf("tv%0d_params", i), 32'(params), 32'(tv[i].e_par));
      adv();
    end
    cfg_we = 0; cmd_load = 0;

    // First sample: start 6 cycles after cmd_load, result DOUT_LAT+1 later.
    send(8'h10, t0);
    chk("first_start_cycle", 32'(t0 - t_ist), 6);
    t1 = -1;
    for (int k = 0; k < 20 && t1 < 0; k++) begin
      settle();
      if (m_valid) begin
        t1 = cyc_n;
        chk("first_m_data", 32'(m_data), 32'(fexp(8'h10)));
      end
      adv();
    end
    chk("first_latency", 32'(t1 - t0), 32'(DOUT_LAT + 1));

    // Five back-to-back samples: one start per 12-cycle period.
    ns0 = n_start; nm0 = n_mv; st_q.delete(); sent = 0;
    s_valid = 1; s_data = 8'($urandom);
    for (int k = 0; k < 120 && (n_mv - nm0) < 5; k++) begin
      settle();
      if (start) sent++;
      adv();
      if (sent >= 5) s_valid = 0;
      else if (st_q.size() > 0 && st_q[$] == cyc_n - 1) s_data = 8'($urandom);
    end
    s_valid = 0;
    chk("b2b_starts", 32'(n_start - ns0), 5);
    chk("b2b_results", 32'(n_mv - nm0), 5);
    for (int i = 1; i < st_q.size(); i++)
      chk("b2b_period", 32'(st_q[i] - st_q[i-1]), 12);

    // Write while busy is dropped; done pulse sets the sticky flag.
    cfg_we = 1; cfg_addr = 3'd2; cfg_wdata = 16'h7777; cyc(); cfg_we = 0;
    iir_done = 1; cyc(); iir_done = 0;
    settle(); chk("done_set", 32'(done_sticky), 1); adv();

    // cmd_load while processing is ignored.
    send(8'h5A, t0);
    repeat (3) cyc();
    cmd_load = 1;
    settle();
    chk("ld_in_proc_ist", 32'(iir_start), 0);
    chk("ld_in_proc_busy", 32'(busy), 1);
    adv(); cmd_load = 0;
    for (int k = 0; k < 15; k++) cyc();

    // Ready tied low: timeout drops to IDLE and a reload clears the flags.
    tie_low = 1;
    t_idle = -1;
    for (int k = 0; k < 120 && t_idle < 0; k++) begin
      settle(); if (!busy) t_idle = cyc_n; adv();
    end
    chk("tmo1_idle", 32'(t_idle >= 0), 1);
    settle();
    chk("tmo1_err", 32'(err_timeout), 1);
    chk("tmo1_done_held", 32'(done_sticky), 1);
    adv();
    cmd_load = 1; s_valid = 1; s_data = 8'h77; cyc(); cmd_load = 0;
    settle();
    chk("reload_err_clr", 32'(err_timeout), 0);
    chk("reload_done_clr", 32'(done_sticky), 0);
    adv();
    t_idle = -1;
    for (int k = 0; k < 100 && t_idle < 0; k++) begin
      settle();
      if (cyc_n == t_ist + 2) chk("b0_unchanged", 32'(params), 16'h0040);
      if (!busy) begin
        t_idle = cyc_n;
        chk("tmo2_err", 32'(err_timeout), 1);
      end
      adv();
    end
    chk("tmo2_len", 32'(t_idle - t_ist), 32'(5 + TIMEOUT));
    s_valid = 0; tie_low = 0; rdy_from = -1;

    // Reset in the middle of processing discards the result.
    cmd_load = 1; cyc(); cmd_load = 0;
    send(8'h3C, t0);
    repeat (4) cyc();
    reset = 1;
    #1 check_zero("midrst");
    model_clear();
    repeat (2) cyc();
    reset = 0;
    for (int k = 0; k < 15; k++) begin
      settle(); chk("post_rst_busy", 32'(busy), 0); adv();
    end

    // Randomized episodes against the models.
    extra_max = 2;
    for (int ep = 0; ep < 4; ep++) begin
      for (int k = 0; k < 6; k++) begin
        cfg_we = 1; cfg_addr = 3'($urandom_range(0, 7)); cfg_wdata = 16'($urandom); cyc();
      end
      cfg_we = ($urandom % 2 == 0); cfg_addr = 3'($urandom_range(0, 4)); cfg_wdata = 16'($urandom);
      cmd_load = 1; cyc(); cmd_load = 0; cfg_we = 0;
      for (int k = 0; k < 150; k++) begin
        s_valid = ($urandom % 2 == 0); s_data = 8'($urandom);
        cfg_we = ($urandom % 8 == 0); cfg_addr = 3'($urandom_range(0, 7)); cfg_wdata = 16'($urandom);
        cmd_load = ($urandom % 32 == 0);
        cyc();
      end
      s_valid = 0; cfg_we = 0; cmd_load = 0; tie_low = 1;
      t_idle = -1;
      for (int k = 0; k < 200 && t_idle < 0; k++) begin
        settle(); if (!busy) t_idle = cyc_n; adv();
      end
      chk("ep_timeout_idle", 32'(t_idle >= 0), 1);
      tie_low = 0; rdy_from = -1;
    end

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iir_seq_ctrl.md
Name: iir_seq_ctrl

Overview:
- Sequencer that drives one iir filter instance.
- Holds a host-writable coefficient bank (a1, a2, b0, b1, b2) and replays it into the filter's 5-cycle params load sequence.
- Feeds samples from a valid/ready input stream into the filter's start/din handshake, captures the one-cycle-valid dout at fixed latency and presents it as an output stream.
- Reports done/timeout status to the host.

Parameters:
- DOUT_LAT, 10, cycles from the start-pulse cycle to the cycle in which filter dout is valid.
- TIMEOUT, 64, max cycles waiting for filter ready (with a sample pending) before error.
- TW, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  3  0=a1 1=a2 2=b0 3=b1 4=b2; 5-7 ignored
- cfg_wdata  in  16  coefficient value
- cmd_load  in  1  pulse: load coefficients and start running
- s_valid  in  1  input sample valid
- s_data  in  8  input sample
- s_ready  out  1  sample accepted when s_valid&s_ready
- m_valid  out  1  one-cycle pulse, m_data updated
- m_data  out  8  last filter output, held
- iir_start  out  1  to filter
- params  out  16  to filter
- start  out  1  to filter
- din  out  8  to filter
- ready  in  1  from filter
- dout  in  8  from filter
- iir_done  in  1  from filter
- busy  out  1  state != IDLE
- done_sticky  out  1  set by iir_done pulse; cleared by cmd_load
- err_timeout  out  1  sticky; cleared by cmd_load

Behaviour:
- Reset (async): state IDLE; all outputs 0; coefficient bank 0.
- Coefficient bank: 5x16 registers, written when cfg_we and state==IDLE; writes in any other state are dropped.
- IDLE: params=a1 continuously. On cmd_load: iir_start=1 for exactly that cycle, clear done_sticky/err_timeout, index<=1, go LOAD.
- LOAD: params=bank[index] for index 1..4 (one per cycle), then go WAIT. iir_start=0 throughout.
- WAIT: s_ready=1 only when ready==1.
  - On s_valid&ready: start=1 and din=s_data combinationally in that cycle, go PROC, latency counter<=1.
  - Timeout counter increments while ready==0 and resets when ready==1. On reaching TIMEOUT: err_timeout<=1, go IDLE.
- PROC: start=0, s_ready=0; ready is ignored (it is stale for 2 cycles after start). Increment counter; when counter==DOUT_LAT, sample dout into m_data, m_valid=1 next cycle, go WAIT.
- Pipelining: only one sample is in flight at a time. The next start is never earlier than the filter's ready re-rise (2 cycles after capture).
- Load timing: first possible start is 6 cycles after cmd_load (filter ready lags its state by one cycle).
- iir_done: any cycle sets done_sticky. In WAIT, a done with ready==0 is expected; the timeout then returns the controller to IDLE. A filter in its idle state never raises ready.
- cmd_load outside IDLE: ignored.
- cmd_load coincident with cfg_we in IDLE: the write lands, and the new value is used if the write is to a1 or later (a1 is read the same cycle; write-first bypass required for a1).
- Simultaneous s_valid and timeout expiry: timeout wins only if ready==0, so no sample is lost.
- Reset mid-PROC: in-flight result discarded, m_valid stays 0.

Decomposition:
- Package iir_seq_pkg: state enum (IDLE, LOAD, WAIT, PROC), coefficient address constants, coefficient width 16, sample width 8.
- One sub-module, iir_coef_bank: 5x16 register file with write port and combinational read port, with write-first bypass.

Test Plan:
- Write a1=0x0100, a2=0xFF80, b0=0x0040, b1=0x0020, b2=0x0010, then pulse cmd_load -> iir_start high 1 cycle, params sequence 0x0100, 0xFF80, 0x0040, 0x0020, 0x0010 on consecutive cycles.
- After load, s_valid with s_data=0x10 held -> start pulse coincides with ready=1, din=0x10; m_valid exactly DOUT_LAT+1 cycles later with m_data equal to the filter's dout in its valid cycle.
- Stream 5 back-to-back samples -> exactly one start per 12-cycle period, 5 m_valid pulses, no start while in PROC.
- Tie filter ready low after load -> err_timeout=1 and busy=0 after 64 cycles; a subsequent cmd_load clears err_timeout.
- cfg_we to b0 during WAIT -> bank unchanged; cmd_load during PROC -> ignored, no iir_start.
- Assert reset during PROC -> all outputs 0 immediately; after release, busy=0 and no m_valid.
